hex_uart_tx: RTL and testbench
==============================

Name: hex_uart_tx

Overview:
- Output stage downstream of the CPU data bus: captures 16-bit bus words on a write strobe and buffers them in a small FIFO.
- Transmits each word over a UART TX line as four uppercase ASCII hex digits, MSB nibble first, followed by CR LF.
- Gives the 16 MHz board a human-readable serial view of the processor's OUT value.

Parameters:
- CLK_HZ, 16000000, input clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- FIFO_DEPTH, 4, words of buffering; power of two, minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- in  input  16  word to print (driven from the bus).
- in_en  input  1  write strobe; pushes `in` on a rising clk edge when asserted.
- full  output  1  FIFO holds FIFO_DEPTH words.
- busy  output  1  a character frame is in progress, or the FIFO is non-empty.
- drop  output  1  sticky; set when a push is rejected because the FIFO is full.
- tx  output  1  UART line, idle high, 8N1, LSB first.

Behaviour:
- Reset is asynchronous, active-low. Assertion at any time, including mid-frame, forces the following within the same cycle:
  - tx=1, busy=0, full=0, drop=0.
  - FIFO pointers and count cleared; state=IDLE; baud counter, bit index and char index cleared.
- Baud timing: CLKS_PER_BIT = CLK_HZ/BAUD, integer division (138 at defaults). Each bit is held for exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
- Push: on a clk edge with in_en=1 and full=0, `in` is written at the write pointer and the count increments.
  - A push with full=1 is discarded and sets drop=1.
  - drop clears only on reset.
  - `full` is evaluated before a same-cycle pop, so a push while full is always rejected even if a pop occurs in that cycle.
- Pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop with 0<count<FIFO_DEPTH leaves the count unchanged.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: tx=1. If count>0, pop the head word into a 16-bit holding register, set char_idx=0, go to LOAD.
  - LOAD: form the current character into an 8-bit shift register, then go to START.
    - char_idx 0..3 select nibbles [15:12], [11:8], [7:4], [3:0].
    - Nibble 0-9 maps to 0x30+n; nibble A-F maps to 0x41+(n-10).
    - char_idx 4 gives 0x0D; char_idx 5 gives 0x0A.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if char_idx<5, increment char_idx and go to LOAD; otherwise go to IDLE.
- Latency: a push into an empty, idle block gives pop on the next edge, LOAD the edge after, and tx falling 3 clk edges after the push edge.
- Back-to-back words: after the LF stop bit, IDLE pops the next word immediately. Inter-frame gap is 1 LOAD cycle within a word and 2 cycles (IDLE+LOAD) between words.
- busy = (state!=IDLE) || (count!=0).
- The holding register is independent of the FIFO, so pushes during transmission never corrupt the word in flight.

Test Plan:
- Single word: reset, then one in_en pulse with in=0xBEEF.
  - UART decoder receives 0x42,0x45,0x45,0x46,0x0D,0x0A.
  - First frame bits: start 0, data 0,1,0,0,0,0,1,0, stop 1; each bit exactly 138 clks.
  - tx falls 3 edges after the push; busy drops after 6 frames.
- Digit mapping: push 0x09A0 and 0xF00F.
  - Received "09A0\r\n" then "F00F\r\n".
  - Exactly 2 cycles of tx=1 between the two words' frames.
- Overflow: with the first word in flight, push 5 words 0x0001..0x0005 back-to-back.
  - Words 0x0001..0x0004 accepted; full=1 after the 4th.
  - 0x0005 dropped and drop=1.
  - Output is the in-flight word followed by 0001..0004 in order; drop stays 1.
- Full with simultaneous pop: FIFO full, IDLE about to pop, push 0x1234 in that cycle.
  - Push rejected, drop=1, count becomes 3.
- Reset mid-frame: assert rst during DATA bit 3 of the second character.
  - tx=1 asynchronously; busy=0, full=0, drop=0.
  - After release, a push of 0x0000 yields clean "0000\r\n" with no residual characters.
- Wrap-around: push and drain 10 words 0x0000..0x0009 spaced so the FIFO never fills.
  - All 10 received in order; pointers wrap at least twice.

Source files
------------

// File: rtl/hex_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hex_uart_tx : buffers 16-bit bus words and prints each as "HHHH\r\n" on 8N1 UART
// Revision 1.0
// ---------------------------------------------------------------------------
module hex_uart_tx #(
  parameter int CLK_HZ     = 16000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        in_en,
  output logic        full,
  output logic        busy,
  output logic        drop,
  output logic        tx
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW           = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          drop_q, drop_d;
  logic          tx_q, tx_d;
  logic [15:0]   hold_q, hold_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    char_idx_q, char_idx_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] baud_q, baud_d;

  logic       push, pop, bit_end;
  logic [3:0] nib;
  logic [7:0] char_byte;

  assign full = (count_q == (PW+1)'(FIFO_DEPTH));
  assign busy = (state_q != S_IDLE) || (count_q != '0);
  assign drop = drop_q;
  assign tx   = tx_q;

  // full is sampled before any same-cycle pop, so a push while full always loses
  assign push    = in_en && !full;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign bit_end = (baud_q == BIT_LAST);

  always_comb begin
    nib = 4'h0;
    case (char_idx_q)
      3'd0:    nib = hold_q[15:12];
      3'd1:    nib = hold_q[11:8];
      3'd2:    nib = hold_q[7:4];
      3'd3:    nib = hold_q[3:0];
      default: nib = 4'h0;
    endcase
    if (char_idx_q == 3'd4)      char_byte = 8'h0D;
    else if (char_idx_q > 3'd4)  char_byte = 8'h0A;
    else if (nib < 4'd10)        char_byte = 8'h30 + {4'h0, nib};
    else                         char_byte = 8'h37 + {4'h0, nib};
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q | (in_en & full);
    hold_d     = hold_q;
    shift_d    = shift_q;
    char_idx_d = char_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    tx_d       = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (!push && pop) count_d = count_q - (PW+1)'(1);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          hold_d     = mem_q[rd_ptr_q];
          char_idx_d = 3'd0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        shift_d = char_byte;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (char_idx_q < 3'd5) begin
            char_idx_d = char_idx_q + 3'd1;
            state_d    = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in;
  end

  // tx is registered so the line is glitch-free; it lags the state by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
      tx_q       <= 1'b1;
      hold_q     <= '0;
      shift_q    <= '0;
      char_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      tx_q       <= tx_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      char_idx_q <= char_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hex_uart_tx : directed self-checking bench with a UART receiver model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_hex_uart_tx;

  // 16 MHz clock with a fast baud keeps the run short: 16000000/921600 = 17
  localparam int CPB   = 17;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        in_en;
  logic        full, busy, drop, tx;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         gap_q[$];

  hex_uart_tx #(
    .CLK_HZ(16000000),
    .BAUD(921600),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(din),
    .in_en(in_en),
    .full(full),
    .busy(busy),
    .drop(drop),
    .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model sampling mid-bit on the falling clock edge; also records
  // the length of the high run preceding each start bit.
  initial begin : rx_model
    int       hi_run, rx_cnt;
    bit       rx_busy;
    logic [7:0] rx_sh;
    hi_run = 0; rx_cnt = 0; rx_busy = 1'b0; rx_sh = 8'h00;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        rx_busy = 1'b0;
        hi_run  = 0;
      end else if (!rx_busy) begin
        if (tx) hi_run++;
        else begin
          gap_q.push_back(hi_run);
          hi_run  = 0;
          rx_busy = 1'b1;
          rx_cnt  = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == CPB / 2) begin
          if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_sh[rx_cnt/CPB-1] = tx;
          else if (rx_cnt / CPB == 9) begin
            rx_q.push_back(tx ? rx_sh : 8'hFF);
            rx_busy = 1'b0;
            hi_run  = CPB / 2 + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge clk);
    din   = v;
    in_en = 1'b1;
    @(posedge clk);
    #1;
    in_en = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rx_q.delete();
    exp_q.delete();
    gap_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target && cyc < 90000) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic measure_run(input logic v, output int len);
    len = 0;
    while (tx === v && len < 2000) begin
      len++;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back(hexc(w[15:12]));
    exp_q.push_back(hexc(w[11:8]));
    exp_q.push_back(hexc(w[7:4]));
    exp_q.push_back(hexc(w[3:0]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
  endtask

  initial begin : stim
    int n, len, t0;
    rst = 1'b0; in_en = 1'b0; din = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",   {31'b0, tx},   32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_drop", {31'b0, drop}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single word: latency, bit timing of 'B' (0x42), total duration
    rx_q.delete(); exp_q.delete(); gap_q.delete();
    push(16'hBEEF);
    t0 = cyc;
    n  = 0;
    while (tx && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("tx_latency", n, 3);
    measure_run(1'b0, len); chk("run_start_b0", len, 2 * CPB);
    measure_run(1'b1, len); chk("run_b1",       len, CPB);
    measure_run(1'b0, len); chk("run_b2_b5",    len, 4 * CPB);
    measure_run(1'b1, len); chk("run_b6",       len, CPB);
    measure_run(1'b0, len); chk("run_b7",       len, CPB);
    measure_run(1'b1, len); chk("run_stop_gap", len, CPB + 1);
    wait_idle(20000);
    chk("busy_duration", cyc - t0, 1 + 6 * (FRAME + 1));
    expect_word(16'hBEEF);
    check_rx("beef");

    // Digit mapping and inter-word gap
    reset_dut();
    push(16'h09A0);
    push(16'hF00F);
    wait_idle(20000);
    expect_word(16'h09A0);
    expect_word(16'hF00F);
    check_rx("digits");
    chk("gap_count",      gap_q.size(), 12);
    chk("gap_in_word",    gap_q[5], CPB + 1);
    chk("gap_word_break", gap_q[6], CPB + 2);

    // Overflow with a word in flight
    reset_dut();
    push(16'hA5A5);
    repeat (3) @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("ovf_full_after4", {31'b0, full}, 32'd1);
        chk("ovf_drop_before", {31'b0, drop}, 32'd0);
      end
      din   = 16'(i);
      in_en = 1'b1;
    end
    @(negedge clk);
    in_en = 1'b0;
    chk("ovf_drop_after", {31'b0, drop}, 32'd1);
    chk("ovf_full_still", {31'b0, full}, 32'd1);
    wait_idle(20000);
    chk("ovf_drop_sticky", {31'b0, drop}, 32'd1);
    expect_word(16'hA5A5);
    for (int i = 1; i <= 4; i++) expect_word(16'(i));
    check_rx("overflow");

    // Push while full in the very cycle IDLE pops: must be rejected
    reset_dut();
    push(16'hC0DE);
    t0 = cyc;
    for (int i = 1; i <= 4; i++) push(16'(i));
    wait_cyc(t0 + 1 + 6 * (FRAME + 1));
    chk("fp_full_pre", {31'b0, full}, 32'd1);
    chk("fp_drop_pre", {31'b0, drop}, 32'd0);
    push(16'h1234);
    chk("fp_drop_post", {31'b0, drop}, 32'd1);
    chk("fp_full_post", {31'b0, full}, 32'd0);
    wait_idle(20000);
    expect_word(16'hC0DE);
    for (int i = 1; i <= 4; i++) expect_word(16'(i));
    check_rx("fullpop");

    // Asynchronous reset during DATA bit 3 of the second character ('E')
    reset_dut();
    push(16'hBEEF);
    t0 = cyc;
    for (int i = 1; i <= 5; i++) push(16'(i));
    wait_cyc(t0 + 2 + (FRAME + 1) + CPB + 3 * CPB + CPB / 2);
    chk("mid_tx_pre",   {31'b0, tx},   32'd0);
    chk("mid_full_pre", {31'b0, full}, 32'd1);
    chk("mid_drop_pre", {31'b0, drop}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_tx",   {31'b0, tx},   32'd1);
    chk("async_busy", {31'b0, busy}, 32'd0);
    chk("async_full", {31'b0, full}, 32'd0);
    chk("async_drop", {31'b0, drop}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    rx_q.delete(); exp_q.delete(); gap_q.delete();
    push(16'h0000);
    wait_idle(20000);
    repeat (50) @(posedge clk);
    #1;
    expect_word(16'h0000);
    check_rx("post_reset");

    // Pointer wrap-around: ten words, one at a time
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      push(16'(i));
      wait_idle(20000);
    end
    for (int i = 0; i < 10; i++) expect_word(16'(i));
    check_rx("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
